// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating an ADXL362-style accelerometer register file.
// SPI pins are oversampled on ClkPort; reads are served from a sample snapshot.
module spi_accel_responder #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PART_ID   = 8'hF2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0] CmdRead  = 8'h0B;
  localparam logic [7:0] CmdWrite = 8'h0A;
  localparam logic [7:0] AddrPwr  = 8'h2D;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRd, StWr, StIgnore} state_e;

  state_e      state_q, state_d;
  logic        sclk_s1_q, sclk_s2_q, sclk_p_q;
  logic        csn_s1_q, csn_s2_q, mosi_s1_q, mosi_s2_q;
  logic        arm_q, arm_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d;
  logic        rd_q, rd_d, miso_q, miso_d;
  logic [7:0]  power_ctl_q, power_ctl_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d, cmd_err_q, cmd_err_d;
  logic [11:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
  logic [11:0] hdx_q, hdx_d, hdy_q, hdy_d, hdz_q, hdz_d;
  logic        pend_q, pend_d;

  logic       sclk_rise, sclk_fall, byte_done;
  logic [7:0] rx_in;

  assign sclk_rise = sclk_s2_q & ~sclk_p_q;
  assign sclk_fall = ~sclk_s2_q & sclk_p_q;
  assign byte_done = sclk_rise & (cnt_q == 3'd7);
  assign rx_in     = {rx_q[6:0], mosi_s2_q};

  // A transaction only counts once csn has been seen high since reset, so a
  // reset landing mid-transaction ignores the rest of that transaction.
  assign busy  = arm_q & ~csn_s2_q;
  assign arm_d = arm_q | csn_s2_q;

  function automatic logic [7:0] reg_read(input logic [7:0]  a,
                                          input logic [11:0] x,
                                          input logic [11:0] y,
                                          input logic [11:0] z,
                                          input logic [7:0]  pc);
    logic [7:0] r;
    case (a)
      8'h00:   r = DEVID_AD;
      8'h01:   r = DEVID_MST;
      8'h02:   r = PART_ID;
      8'h08:   r = x[11:4];
      8'h09:   r = y[11:4];
      8'h0A:   r = z[11:4];
      8'h0E:   r = x[7:0];
      8'h0F:   r = {{4{x[11]}}, x[11:8]};
      8'h10:   r = y[7:0];
      8'h11:   r = {{4{y[11]}}, y[11:8]};
      8'h12:   r = z[7:0];
      8'h13:   r = {{4{z[11]}}, z[11:8]};
      AddrPwr: r = pc;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_p_q    <= 1'b0;
      csn_s1_q    <= 1'b0;
      csn_s2_q    <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      arm_q       <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 8'h00;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      power_ctl_q <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      cmd_err_q   <= 1'b0;
      shx_q       <= 12'h000;
      shy_q       <= 12'h000;
      shz_q       <= 12'h000;
      hdx_q       <= 12'h000;
      hdy_q       <= 12'h000;
      hdz_q       <= 12'h000;
      pend_q      <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_p_q    <= sclk_s2_q;
      csn_s1_q    <= csn;
      csn_s2_q    <= csn_s1_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      arm_q       <= arm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      power_ctl_q <= power_ctl_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_err_q   <= cmd_err_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
      shz_q       <= shz_d;
      hdx_q       <= hdx_d;
      hdy_q       <= hdy_d;
      hdz_q       <= hdz_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (csn_s2_q) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (arm_q) state_d = StCmd;
        StCmd: begin
          if (byte_done) begin
            state_d = (rx_in == CmdRead || rx_in == CmdWrite) ? StAddr : StIgnore;
          end
        end
        StAddr:   if (byte_done) state_d = rd_q ? StRd : StWr;
        StRd:     state_d = StRd;
        StWr:     state_d = StWr;
        StIgnore: state_d = StIgnore;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rd_d        = rd_q;
    miso_d      = miso_q;
    power_ctl_d = power_ctl_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_err_d   = 1'b0;
    if (csn_s2_q || state_q == StIdle || state_q == StIgnore) begin
      cnt_d  = 3'd0;
      miso_d = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_d  = rx_in;
        cnt_d = cnt_q + 3'd1;
      end
      unique case (state_q)
        StCmd: begin
          if (byte_done) begin
            if (rx_in == CmdRead) rd_d = 1'b1;
            else if (rx_in == CmdWrite) rd_d = 1'b0;
            else cmd_err_d = 1'b1;
          end
        end
        StAddr: begin
          if (byte_done) begin
            ptr_d = rx_in;
            if (rd_q) tx_d = reg_read(rx_in, shx_q, shy_q, shz_q, power_ctl_q);
          end
        end
        StRd: begin
          if (byte_done) begin
            ptr_d = ptr_q + 8'd1;
            tx_d  = reg_read(ptr_q + 8'd1, shx_q, shy_q, shz_q, power_ctl_q);
          end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        StWr: begin
          if (byte_done) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_in;
            if (ptr_q == AddrPwr) power_ctl_d = rx_in;
            ptr_d = ptr_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes during a transaction are parked so a burst never mixes samples.
  always_comb begin
    shx_d  = shx_q;
    shy_d  = shy_q;
    shz_d  = shz_q;
    hdx_d  = hdx_q;
    hdy_d  = hdy_q;
    hdz_d  = hdz_q;
    pend_d = pend_q;
    if (sample_valid) begin
      if (!busy) begin
        shx_d  = x_data;
        shy_d  = y_data;
        shz_d  = z_data;
        pend_d = 1'b0;
      end else begin
        hdx_d  = x_data;
        hdy_d  = y_data;
        hdz_d  = z_data;
        pend_d = 1'b1;
      end
    end else if (!busy && pend_q) begin
      shx_d  = hdx_q;
      shy_d  = hdy_q;
      shz_d  = hdz_q;
      pend_d = 1'b0;
    end
  end

  assign miso      = miso_q;
  assign power_ctl = power_ctl_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cmd_err   = cmd_err_q;

endmodule
